// File: rtl/dt_pkg.sv
// Shared constants and FSM state type for the distance-transform statistics path.
// Image geometry, result-memory widths and the statistics accumulator widths.
package dt_pkg;

    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int PIX_CNT    = IMG_W * IMG_H;
    localparam int RES_ADDR_W = 14;
    localparam int DIST_W     = 8;
    localparam int SUM_W      = 22;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FINI  = 3'd4
    } stat_state_t;

endpackage

// File: rtl/dt_stat_acc.sv
// Running max/argmax, non-zero pixel count and (with DT_STAT_SUM_EN) distance sum.
// Latency: one cycle from a valid sample to updated outputs; no backpressure, every valid sample is taken.
// i_clr has priority over i_vld and zeroes every accumulator.
module dt_stat_acc
    import dt_pkg::*;
#(
    parameter int ADDR_W = RES_ADDR_W,
    parameter int DATA_W = DIST_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_val,
    input  logic [ADDR_W-1:0] i_addr,
`ifdef DT_STAT_SUM_EN
    output logic [SUM_W-1:0]  o_dist_sum,
`endif
    output logic [DATA_W-1:0] o_max_val,
    output logic [ADDR_W-1:0] o_max_addr,
    output logic [ADDR_W:0]   o_obj_cnt
);

    logic [DATA_W-1:0] r_max_val;
    logic [ADDR_W-1:0] r_max_addr;
    logic [ADDR_W:0]   r_obj_cnt;
    logic              w_nonzero;

    assign w_nonzero = (i_val != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max_val  <= '0;
            r_max_addr <= '0;
            r_obj_cnt  <= '0;
        end else if (i_clr) begin
            r_max_val  <= '0;
            r_max_addr <= '0;
            r_obj_cnt  <= '0;
        end else if (i_vld) begin
            if (w_nonzero) begin
                r_obj_cnt <= r_obj_cnt + 1'b1;
            end
            // Strict compare: on a tie the earlier (lower) address is kept.
            if (i_val > r_max_val) begin
                r_max_val  <= i_val;
                r_max_addr <= i_addr;
            end
        end
    end

`ifdef DT_STAT_SUM_EN
    logic [SUM_W-1:0] r_dist_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dist_sum <= '0;
        end else if (i_clr) begin
            r_dist_sum <= '0;
        end else if (i_vld && w_nonzero) begin
            r_dist_sum <= r_dist_sum + {{(SUM_W-DATA_W){1'b0}}, i_val};
        end
    end

    assign o_dist_sum = r_dist_sum;
`endif

    assign o_max_val  = r_max_val;
    assign o_max_addr = r_max_addr;
    assign o_obj_cnt  = r_obj_cnt;

endmodule

// File: rtl/dt_stat.sv
// Scans the distance-transform result memory once after start and reports max, argmax, object count (+ sum with DT_STAT_SUM_EN).
// Latency: start sampled at edge 0 -> done after IMG_W*IMG_H+3 cycles; one-cycle memory read latency.
// No backpressure: the memory port is owned outright once the transform is done; start outside IDLE is ignored.
module dt_stat
    import dt_pkg::*;
#(
    parameter int IMG_W  = dt_pkg::IMG_W,
    parameter int IMG_H  = dt_pkg::IMG_H,
    parameter int ADDR_W = RES_ADDR_W,
    parameter int DATA_W = DIST_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_res_rd,
    output logic [ADDR_W-1:0] o_res_addr,
    input  logic [DATA_W-1:0] i_res_di,
    output logic              o_done,
    output logic [DATA_W-1:0] o_max_val,
    output logic [ADDR_W-1:0] o_max_addr,
`ifdef DT_STAT_SUM_EN
    output logic [SUM_W-1:0]  o_dist_sum,
`endif
    output logic [ADDR_W:0]   o_obj_cnt
);

    localparam int                NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    stat_state_t       r_state;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_vld;
    logic [ADDR_W-1:0] r_vaddr;
    logic              w_clr;

    assign w_clr = (r_state == ST_CLEAR);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_vld   <= 1'b0;
            r_vaddr <= '0;
        end else begin
            // Tags the sample returning next cycle with the address issued now.
            r_vld   <= r_rd;
            r_vaddr <= r_addr;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_CLEAR;
                        r_done  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    r_rd    <= 1'b1;
                    r_addr  <= '0;
                    r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_addr == LAST_ADDR) begin
                        r_rd    <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_FINI;
                end
                ST_FINI: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd    <= 1'b0;
                end
            endcase
        end
    end

    dt_stat_acc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_vld      (r_vld),
        .i_val      (i_res_di),
        .i_addr     (r_vaddr),
`ifdef DT_STAT_SUM_EN
        .o_dist_sum (o_dist_sum),
`endif
        .o_max_val  (o_max_val),
        .o_max_addr (o_max_addr),
        .o_obj_cnt  (o_obj_cnt)
    );

    assign o_res_rd   = r_rd;
    assign o_res_addr = r_addr;
    assign o_done     = r_done;

endmodule

// File: tb/tb_dt_stat.sv
// Directed table-driven bench for dt_stat with a one-cycle-latency result memory model.
module tb_dt_stat;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di   = 8'd0;
    logic        done;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] obj_cnt;
`ifdef DT_STAT_SUM_EN
    logic [21:0] dist_sum;
`endif

    logic [7:0] mem [0:16383];
    int total = 0;
    int bad   = 0;

    typedef struct {
        string nm;
        int    pat;
        int    e_max;
        int    e_addr;
        int    e_cnt;
        int    e_sum;
    } vec_t;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    dt_stat dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .o_res_rd   (res_rd),
        .o_res_addr (res_addr),
        .i_res_di   (res_di),
        .o_done     (done),
        .o_max_val  (max_val),
        .o_max_addr (max_addr),
`ifdef DT_STAT_SUM_EN
        .o_dist_sum (dist_sum),
`endif
        .o_obj_cnt  (obj_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
        case (pat)
            1: mem[8321] = 8'd5;
            2: begin
                mem[200]  = 8'd7;
                mem[9000] = 8'd7;
                mem[300]  = 8'd3;
            end
            3: begin
                for (int y = 1; y < 127; y++)
                    for (int x = 1; x < 127; x++)
                        mem[y*128 + x] = 8'd255;
            end
            4: mem[0] = 8'd1;
            default: ;
        endcase
    endtask

    // Pulses start for one cycle and counts cycles from the accepting edge until done.
    task automatic run_scan(input int mid_start, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk("done_drop_on_start", {31'd0, done}, 32'd0);
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100) begin
                chk("scan_addr", {18'd0, res_addr}, 32'd99);
                chk("scan_rd", {31'd0, res_rd}, 32'd1);
            end
            if (mid_start != 0 && cyc == mid_start) start = 1'b1;
            if (mid_start != 0 && cyc == mid_start + 3) start = 1'b0;
        end
        chk("latency", cyc, 32'd16387);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd"},       {31'd0, res_rd},   32'd0);
        chk({tag, "_addr"},     {18'd0, res_addr}, 32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_max_val"},  {24'd0, max_val},  32'd0);
        chk({tag, "_max_addr"}, {18'd0, max_addr}, 32'd0);
        chk({tag, "_obj_cnt"},  {17'd0, obj_cnt},  32'd0);
`ifdef DT_STAT_SUM_EN
        chk({tag, "_dist_sum"}, {10'd0, dist_sum}, 32'd0);
`endif
    endtask

    initial begin
        vec_t tv [4];
        int   cyc;

        tv[0] = '{"all_zero",  0, 0,   0,    0,     0};
        tv[1] = '{"single",    1, 5,   8321, 1,     5};
        tv[2] = '{"tie",       2, 7,   200,  3,     17};
        tv[3] = '{"interior",  3, 255, 129,  15876, 4048380};

        fill(0);
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            fill(tv[i].pat);
            run_scan(0, cyc);
            chk({tv[i].nm, "_max_val"},  {24'd0, max_val},  tv[i].e_max);
            chk({tv[i].nm, "_max_addr"}, {18'd0, max_addr}, tv[i].e_addr);
            chk({tv[i].nm, "_obj_cnt"},  {17'd0, obj_cnt},  tv[i].e_cnt);
`ifdef DT_STAT_SUM_EN
            chk({tv[i].nm, "_dist_sum"}, {10'd0, dist_sum}, tv[i].e_sum);
`endif
            repeat (3) @(negedge clk);
        end

        // Abort a scan of the interior image part-way through.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5000) @(negedge clk);
        chk("pre_abort_rd", {31'd0, res_rd}, 32'd1);
        chk("pre_abort_cnt_nonzero", {31'd0, (obj_cnt != 15'd0)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Rescan after abort, with a stray start pulsed mid-scan.
        fill(4);
        run_scan(8000, cyc);
        chk("post_abort_max_val",  {24'd0, max_val},  32'd1);
        chk("post_abort_max_addr", {18'd0, max_addr}, 32'd0);
        chk("post_abort_obj_cnt",  {17'd0, obj_cnt},  32'd1);
`ifdef DT_STAT_SUM_EN
        chk("post_abort_dist_sum", {10'd0, dist_sum}, 32'd1);
`endif

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("done_hold", {31'd0, done}, 32'd1);
        end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("done_drop_next_start", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dt_stat.md
Name: dt_stat

Overview:
- Downstream consumer of the distance-transform stage.
- Starts when the transform asserts done, then scans the 128x128 result memory (8-bit distance per pixel) once, in raster order.
- Reports:
  - maximum distance and the first address holding it,
  - object-pixel count (non-zero distances),
  - optionally the distance sum.
- Shares the res memory port with the transform; the transform has finished before this block drives it, so no arbitration is needed.

Parameters:
- IMG_W, 128, image width in pixels.
- IMG_H, 128, image height in pixels.
- ADDR_W, 14, res address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, distance value width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-or-more-cycle pulse; wired to the transform's done.
- res_rd  out  1  result-memory read enable.
- res_addr  out  ADDR_W  result-memory read address.
- res_di  in  DATA_W  result-memory read data.
- done  out  1  statistics valid.
- max_val  out  DATA_W  maximum distance found.
- max_addr  out  ADDR_W  lowest address holding max_val.
- obj_cnt  out  ADDR_W+1  number of pixels with distance != 0.
- dist_sum  out  22  sum of all distances (present only with DT_STAT_SUM_EN).

Behaviour:
- Reset (async, active-low): FSM to IDLE.
  - res_rd=0, res_addr=0, done=0, max_val=0, max_addr=0, obj_cnt=0, dist_sum=0.
  - Internal address and valid pipeline cleared.
  - Reset mid-scan aborts immediately; no partial results are retained.
- Memory timing: res_rd/res_addr are registered. Data for the address presented in cycle N is sampled from res_di at the rising edge ending cycle N+1 (one-cycle read latency).
- FSM states: IDLE, CLEAR, SCAN, DRAIN, FINI.
- IDLE:
  - Waits for start=1.
  - On start: go to CLEAR and drop done to 0.
  - start is level-tolerant; only the IDLE-state sample matters.
- CLEAR (1 cycle):
  - Zero the accumulators, max_val and max_addr.
  - res_addr=0, res_rd=1.
  - Next state SCAN.
- SCAN:
  - res_rd=1; res_addr increments by 1 every cycle.
  - A one-bit valid/address pipeline tags each returning sample with its address.
  - For every valid sample v at address a:
    - if v != 0: obj_cnt += 1 (and dist_sum += v with the option).
    - if v > max_val (strictly greater): max_val=v, max_addr=a. Ties keep the earlier, lower address.
  - When res_addr == IMG_W*IMG_H-1 has been issued: go to DRAIN.
- DRAIN (1 cycle):
  - res_rd=0, res_addr holds.
  - The last in-flight sample (address 16383) is accumulated.
  - Next state FINI.
- FINI:
  - done=1.
  - Result outputs frozen and stable while done=1.
  - Return to IDLE.
- Post-scan:
  - done stays 1 in IDLE until the next start is accepted.
  - A start received outside IDLE is ignored.
- Latency: start sampled at edge 0 → done=1 after 1 + 16384 + 1 + 1 cycles (16387 cycles).
- Width rules:
  - obj_cnt is 15 bits and reaches 16384 without overflow.
  - dist_sum worst case 16384*255 = 4,177,920, which fits 22 bits.
  - All-zero image gives max_val=0, max_addr=0, obj_cnt=0.
- Result outputs are registered only; no combinational path from res_di to the outputs.

Optional Feature:
- Macro: DT_STAT_SUM_EN.
- Defined: dist_sum port and its 22-bit accumulator exist and update as described.
- Undefined: dist_sum port and accumulator are absent. All other behaviour and timing are identical.

Decomposition:
- Shared package (dt_pkg):
  - IMG_W, IMG_H, PIX_CNT=16384, RES_ADDR_W=14, DIST_W=8, SUM_W=22.
  - FSM state enum for dt_stat.
- Sub-module: dt_stat_acc.
  - Inputs: valid, value, address.
  - Holds the max/argmax compare, obj_cnt and optional sum.
  - Has a clear input driven in CLEAR.
  - The top keeps the FSM and the address generator.

Test Plan:
- All-zero memory, start pulse → done after 16387 cycles; max_val=0, max_addr=0, obj_cnt=0, dist_sum=0.
- Single pixel mem[8321]=5, rest 0 → max_val=5, max_addr=8321, obj_cnt=1, dist_sum=5.
- Tie: mem[200]=7, mem[9000]=7, mem[300]=3 → max_val=7, max_addr=200, obj_cnt=3, dist_sum=17.
- Full interior: all 126x126 interior pixels =255, border 0 → max_val=255, max_addr=129, obj_cnt=15876, dist_sum=4,048,380 (no overflow).
- Reset: assert reset low at cycle 5000 of a scan → all outputs 0 immediately. A later start with mem[0]=1 → obj_cnt=1, max_addr=0.
- Protocol: second start asserted mid-SCAN is ignored; done stays 1 across idle cycles and drops to 0 the cycle after the next start is accepted.
